// File: rtl/nios2_cpu_pio_pkg.sv
// Shared constants for the Nios II CPU PIO peripherals: register word addresses
// and the default LED count.
package nios2_cpu_pio_pkg;

    localparam logic [2:0] ADDR_DATA         = 3'd0;
    localparam logic [2:0] ADDR_OUTPUT       = 3'd1;
    localparam logic [2:0] ADDR_BLINK_MASK   = 3'd2;
    localparam logic [2:0] ADDR_BLINK_PERIOD = 3'd3;
    localparam logic [2:0] ADDR_OUTSET       = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR     = 3'd5;

    localparam int LED_WIDTH_DEFAULT = 10;

endpackage

// File: rtl/nios2_cpu_led_blink_timer.sv
// Free-running blink timer: phase toggles every 'period' clocks; a period of 0
// stops it, and a period write restarts it from phase 0.
module nios2_cpu_led_blink_timer #(
    parameter int PERIOD_W = 24
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [PERIOD_W-1:0] period,
    input  logic                period_wr,
    output logic                phase
);

    logic [PERIOD_W-1:0] counter;
    logic                terminal;

    // counter < period always holds, so a plain equality compare cannot miss
    assign terminal = (counter == period - PERIOD_W'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            counter <= '0;
            phase   <= 1'b0;
        end else if (period_wr || period == '0) begin
            counter <= '0;
            phase   <= 1'b0;
        end else if (terminal) begin
            counter <= '0;
            phase   <= ~phase;
        end else begin
            counter <= counter + PERIOD_W'(1);
        end
    end

endmodule

// File: rtl/nios2_cpu_led.sv
// Avalon-MM LED output PIO with set/clear aliases; the hardware blink engine is
// built only when NIOS2_CPU_LED_BLINK_EN is defined.
module nios2_cpu_led
    import nios2_cpu_pio_pkg::*;
#(
    parameter int               WIDTH       = LED_WIDTH_DEFAULT,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               PERIOD_W    = 24
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    logic             wr;
    logic [WIDTH-1:0] data_reg;
    logic [WIDTH-1:0] out_next;
    logic [31:0]      read_mux;
    logic             unused_wdata;

    assign wr           = chipselect && !write_n;
    assign unused_wdata = ^writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_reg <= RESET_VALUE;
        end else if (wr) begin
            case (address)
                ADDR_DATA:     data_reg <= writedata[WIDTH-1:0];
                ADDR_OUTSET:   data_reg <= data_reg | writedata[WIDTH-1:0];
                ADDR_OUTCLEAR: data_reg <= data_reg & ~writedata[WIDTH-1:0];
                default:       data_reg <= data_reg;
            endcase
        end
    end

`ifdef NIOS2_CPU_LED_BLINK_EN
    logic [WIDTH-1:0]    blink_mask;
    logic [PERIOD_W-1:0] blink_period;
    logic                period_wr;
    logic                phase;

    assign period_wr = wr && (address == ADDR_BLINK_PERIOD);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_mask   <= '0;
            blink_period <= '0;
        end else begin
            if (wr && address == ADDR_BLINK_MASK)
                blink_mask <= writedata[WIDTH-1:0];
            if (period_wr)
                blink_period <= writedata[PERIOD_W-1:0];
        end
    end

    nios2_cpu_led_blink_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_blink_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .period    (blink_period),
        .period_wr (period_wr),
        .phase     (phase)
    );

    // Masked bits are forced dark during the odd phase
    assign out_next = data_reg & ~(blink_mask & {WIDTH{phase}});

    always_comb begin
        read_mux = '0;
        case (address)
            ADDR_DATA:         read_mux = 32'(data_reg);
            ADDR_OUTPUT:       read_mux = 32'(out_port);
            ADDR_BLINK_MASK:   read_mux = 32'(blink_mask);
            ADDR_BLINK_PERIOD: read_mux = 32'(blink_period);
            default:           read_mux = '0;
        endcase
    end
`else
    assign out_next = data_reg;

    always_comb begin
        read_mux = '0;
        case (address)
            ADDR_DATA:   read_mux = 32'(data_reg);
            ADDR_OUTPUT: read_mux = 32'(data_reg);
            default:     read_mux = '0;
        endcase
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_port <= RESET_VALUE;
            readdata <= '0;
        end else begin
            out_port <= out_next;
            readdata <= read_mux;
        end
    end

endmodule
